// File: rtl/buffered_uart_pkg.sv
// Shared definitions for buffered_uart: register offsets, STATUS/ERR bit
// positions, TX/RX state encodings and the parity helper.
package buffered_uart_pkg;

   localparam logic [1:0] REG_CLK_DIV = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DATA    = 2'd2;
   localparam logic [1:0] REG_ERR     = 2'd3;

   localparam int STAT_TX_NOT_FULL  = 0;
   localparam int STAT_RX_NONEMPTY  = 1;
   localparam int STAT_TX_FULL      = 2;
   localparam int STAT_TX_IDLE      = 3;
   localparam int STAT_TX_LEVEL_LSB = 8;
   localparam int STAT_RX_LEVEL_LSB = 16;

   localparam int ERR_FRAMING     = 0;
   localparam int ERR_RX_OVERRUN  = 1;
   localparam int ERR_TX_OVERFLOW = 2;
   localparam int ERR_PARITY      = 3;
   localparam int ERR_PARITY_ON   = 8;
   localparam int ERR_PARITY_ODD  = 9;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PARITY    = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_HIGH = 3'd5
   } rx_state_e;

   // Even parity makes the total count of ones even; odd flips the bit.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/buffered_uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Push and pop in the same cycle both succeed, even when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   assign level     = count_q;
   assign pop_data  = mem[rd_ptr_q];
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (do_push_s) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/buffered_uart.sv
// Buffered UART with TX/RX byte FIFOs behind a four-register bus window.
// Parity support is compiled in only when BUFFERED_UART_PARITY_EN is defined.
module buffered_uart
   import buffered_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_in,
   output logic        tx_out,
   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]           reg_idx;
   logic                 data_rd_s, data_wr_s, err_wr_s, tx_ovf_s;
   logic [DIV_WIDTH-1:0] clk_div_q, clk_div_d;
   logic [3:0]           err_q, err_d, err_clr_s, rx_err_set_s;
   logic                 parity_on_s, parity_odd_s;

   logic                 tx_pop_s, tx_full_s, tx_empty_s;
   logic [7:0]           tx_head_s;
   logic [LW-1:0]        tx_level_s;
   logic                 rx_push_s, rx_full_s, rx_empty_s;
   logic [7:0]           rx_head_s;
   logic [LW-1:0]        rx_level_s;
   logic [8:0]           tx_level9_s, rx_level9_s;
   logic [31:0]          status_s;

   tx_state_e            tx_state_q, tx_state_d;
   logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic [7:0]           tx_byte_q, tx_byte_d;
   logic                 tx_out_q, tx_out_d;

   rx_state_e            rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic [7:0]           rx_byte_q, rx_byte_d;
   logic                 rx_par_err_q, rx_par_err_d;
   logic                 rx_prev_q, rx_prev_d;

   logic                 unused_s;

   assign reg_idx   = address_in[3:2];
   assign data_rd_s = sel_in && read_in && (reg_idx == REG_DATA);
   assign data_wr_s = sel_in && write_mask_in[0] && (reg_idx == REG_DATA);
   assign err_wr_s  = sel_in && (reg_idx == REG_ERR);
   assign tx_ovf_s  = data_wr_s && tx_full_s && !tx_pop_s;
   assign tx_out    = tx_out_q;
   assign unused_s  = ^{address_in[31:4], address_in[1:0], write_value_in[31:8],
                        tx_level9_s[8], rx_level9_s[8]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(data_wr_s), .push_data(write_value_in[7:0]),
      .pop(tx_pop_s), .pop_data(tx_head_s), .full(tx_full_s), .empty(tx_empty_s),
      .level(tx_level_s)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push_s), .push_data(rx_byte_q),
      .pop(data_rd_s), .pop_data(rx_head_s), .full(rx_full_s), .empty(rx_empty_s),
      .level(rx_level_s)
   );

`ifdef BUFFERED_UART_PARITY_EN
   localparam logic [3:0] ERR_IMPL = 4'hF;
   logic parity_on_q, parity_on_d, parity_odd_q, parity_odd_d;

   always_comb begin
      parity_on_d  = parity_on_q;
      parity_odd_d = parity_odd_q;
      if (err_wr_s && write_mask_in[1]) begin
         parity_on_d  = write_value_in[ERR_PARITY_ON];
         parity_odd_d = write_value_in[ERR_PARITY_ODD];
      end else begin
         parity_on_d  = parity_on_q;
         parity_odd_d = parity_odd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_on_q  <= 1'b0;
         parity_odd_q <= 1'b0;
      end else begin
         parity_on_q  <= parity_on_d;
         parity_odd_q <= parity_odd_d;
      end
   end

   assign parity_on_s  = parity_on_q;
   assign parity_odd_s = parity_odd_q;
`else
   localparam logic [3:0] ERR_IMPL = 4'h7;
   assign parity_on_s  = 1'b0;
   assign parity_odd_s = 1'b0;
`endif

   always_comb begin
      clk_div_d = clk_div_q;
      err_clr_s = 4'h0;
      if (sel_in && (reg_idx == REG_CLK_DIV)) begin
         for (int i = 0; i < DIV_WIDTH; i++) begin
            if (write_mask_in[i/8]) clk_div_d[i] = write_value_in[i];
            else                    clk_div_d[i] = clk_div_q[i];
         end
      end else begin
         clk_div_d = clk_div_q;
      end
      if (err_wr_s && write_mask_in[0]) err_clr_s = write_value_in[3:0];
      else                              err_clr_s = 4'h0;
      // New events win over a simultaneous write-1-to-clear.
      err_d = ((err_q & ~err_clr_s) | rx_err_set_s | {1'b0, tx_ovf_s, 2'b00}) & ERR_IMPL;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_byte_d  = tx_byte_q;
      tx_pop_s   = 1'b0;
      if (tx_state_q == TX_IDLE) begin
         if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_byte_d  = tx_head_s;
            tx_state_d = TX_START;
            tx_cnt_d   = clk_div_q;
         end else begin
            tx_state_d = TX_IDLE;
         end
      end else if (tx_cnt_q != '0) begin
         tx_cnt_d = tx_cnt_q - 1'b1;
      end else begin
         tx_cnt_d = clk_div_q;
         case (tx_state_q)
            TX_START: begin
               tx_state_d = TX_DATA;
               tx_bit_d   = 3'd0;
            end
            TX_DATA: begin
               if (tx_bit_q == 3'd7) tx_state_d = parity_on_s ? TX_PARITY : TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end
            TX_PARITY: tx_state_d = TX_STOP;
            TX_STOP: begin
               if (!tx_empty_s) begin
                  tx_pop_s   = 1'b1;
                  tx_byte_d  = tx_head_s;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
      case (tx_state_d)
         TX_START:  tx_out_d = 1'b0;
         TX_DATA:   tx_out_d = tx_byte_d[tx_bit_d];
         TX_PARITY: tx_out_d = parity_bit(tx_byte_d, parity_odd_s);
         default:   tx_out_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_byte_d    = rx_byte_q;
      rx_par_err_d = rx_par_err_q;
      rx_prev_d    = rx_in;
      rx_push_s    = 1'b0;
      rx_err_set_s = 4'h0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_in) begin
               rx_state_d = RX_START;
               rx_cnt_d   = clk_div_q >> 1;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_in) rx_state_d = RX_IDLE;
            else       rx_state_d = RX_WAIT_HIGH;
         end
         default: begin
            if (rx_cnt_q != '0) begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end else begin
               rx_cnt_d = clk_div_q;
               case (rx_state_q)
                  RX_START: begin
                     if (rx_in) begin
                        rx_state_d = RX_IDLE;
                     end else begin
                        rx_state_d   = RX_DATA;
                        rx_bit_d     = 3'd0;
                        rx_par_err_d = 1'b0;
                     end
                  end
                  RX_DATA: begin
                     rx_byte_d[rx_bit_q] = rx_in;
                     if (rx_bit_q == 3'd7) rx_state_d = parity_on_s ? RX_PARITY : RX_STOP;
                     else                  rx_bit_d   = rx_bit_q + 3'd1;
                  end
                  RX_PARITY: begin
                     rx_par_err_d = (rx_in != parity_bit(rx_byte_q, parity_odd_s));
                     rx_state_d   = RX_STOP;
                  end
                  RX_STOP: begin
                     if (rx_in) begin
                        rx_state_d = RX_IDLE;
                        if (rx_par_err_q)                  rx_err_set_s[ERR_PARITY]     = 1'b1;
                        else if (rx_full_s && !data_rd_s)  rx_err_set_s[ERR_RX_OVERRUN] = 1'b1;
                        else                               rx_push_s                    = 1'b1;
                     end else begin
                        rx_err_set_s[ERR_FRAMING] = 1'b1;
                        rx_state_d                = RX_WAIT_HIGH;
                     end
                  end
                  default: rx_state_d = RX_IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_div_q    <= '1;
         err_q        <= 4'h0;
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= 3'd0;
         tx_byte_q    <= 8'h00;
         tx_out_q     <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= 3'd0;
         rx_byte_q    <= 8'h00;
         rx_par_err_q <= 1'b0;
         rx_prev_q    <= 1'b1;
      end else begin
         clk_div_q    <= clk_div_d;
         err_q        <= err_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_byte_q    <= tx_byte_d;
         tx_out_q     <= tx_out_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_byte_q    <= rx_byte_d;
         rx_par_err_q <= rx_par_err_d;
         rx_prev_q    <= rx_prev_d;
      end
   end

   assign tx_level9_s = 9'(tx_level_s);
   assign rx_level9_s = 9'(rx_level_s);

   always_comb begin
      status_s                                        = 32'h0;
      status_s[STAT_TX_NOT_FULL]                      = !tx_full_s;
      status_s[STAT_RX_NONEMPTY]                      = !rx_empty_s;
      status_s[STAT_TX_FULL]                          = tx_full_s;
      status_s[STAT_TX_IDLE]                          = (tx_state_q == TX_IDLE) && tx_empty_s;
      status_s[STAT_TX_LEVEL_LSB +: 8]                = tx_level9_s[7:0];
      status_s[STAT_RX_LEVEL_LSB +: 8]                = rx_level9_s[7:0];
      read_value_out                                  = 32'h0;
      if (sel_in) begin
         case (reg_idx)
            REG_CLK_DIV: read_value_out = 32'(clk_div_q);
            REG_STATUS:  read_value_out = status_s;
            REG_DATA:    read_value_out = rx_empty_s ? 32'hFFFF_FFFF : {24'h0, rx_head_s};
            REG_ERR:     read_value_out = {22'h0, parity_odd_s, parity_on_s, 4'h0, err_q};
            default:     read_value_out = 32'h0;
         endcase
      end else begin
         read_value_out = 32'h0;
      end
   end

endmodule

// File: tb/tb_buffered_uart.sv
// Directed self-checking bench for buffered_uart: register access, TX framing,
// TX FIFO overflow, RX reception, glitch/framing/overrun/parity handling.
module tb_buffered_uart;
   import buffered_uart_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_in = 1'b1;
   logic        tx_out;
   logic [31:0] address_in = 32'h0;
   logic        sel_in = 1'b0;
   logic        read_in = 1'b0;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in = 4'h0;
   logic [31:0] write_value_in = 32'h0;

   int n_vec = 0;
   int n_err = 0;
   int p_cyc = 65536;
   int cyc = 0;
   int b2b = 0;
   int last_start = -1000000;
   logic [7:0]  tx_exp_q[$];
   logic [31:0] rx_exp_q[$];

   buffered_uart #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .tx_out(tx_out),
      .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
      .read_value_out(read_value_out), .write_mask_in(write_mask_in),
      .write_value_in(write_value_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] r, input logic [31:0] v, input logic [3:0] m);
      @(negedge clk);
      address_in = {28'h0, r, 2'b00}; sel_in = 1'b1; read_in = 1'b0;
      write_mask_in = m; write_value_in = v;
      @(posedge clk); #1;
      sel_in = 1'b0; write_mask_in = 4'h0;
   endtask

   task automatic bus_rd(input logic [1:0] r, output logic [31:0] v);
      @(negedge clk);
      address_in = {28'h0, r, 2'b00}; sel_in = 1'b1; read_in = 1'b1; write_mask_in = 4'h0;
      #1 v = read_value_out;
      @(posedge clk); #1;
      sel_in = 1'b0; read_in = 1'b0;
   endtask

   task automatic set_div(input int d);
      bus_wr(REG_CLK_DIV, 32'(d), 4'hF);
      p_cyc = d + 1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_b, input logic has_par, input logic par_b);
      @(negedge clk);
      rx_in = 1'b0;
      repeat (p_cyc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (p_cyc) @(negedge clk);
      end
      if (has_par) begin
         rx_in = par_b;
         repeat (p_cyc) @(negedge clk);
      end
      rx_in = stop_b;
      repeat (p_cyc) @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * p_cyc) @(negedge clk);
   endtask

   // Decodes every frame on tx_out and compares it with the TX scoreboard.
   always begin : tx_mon
      logic [7:0] b;
      @(negedge clk);
      if (!reset && tx_out === 1'b0) begin
         if (cyc - last_start == 10 * p_cyc) b2b++;
         last_start = cyc;
         repeat (p_cyc / 2) @(negedge clk);
         chk("tx_mon_start", {31'h0, tx_out}, 32'h0);
         for (int i = 0; i < 8; i++) begin
            repeat (p_cyc) @(negedge clk);
            b[i] = tx_out;
         end
         repeat (p_cyc) @(negedge clk);
         chk("tx_mon_stop", {31'h0, tx_out}, 32'h1);
         chk("tx_mon_expected", {31'h0, (tx_exp_q.size() != 0)}, 32'h1);
         if (tx_exp_q.size() != 0) chk("tx_mon_byte", {24'h0, b}, {24'h0, tx_exp_q.pop_front()});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [9:0]  pat;
      int k;

      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      chk("reset_tx_out", {31'h0, tx_out}, 32'h1);
      bus_rd(REG_STATUS, v);  chk("reset_status", v, 32'h0000_0009);
      bus_rd(REG_CLK_DIV, v); chk("reset_clk_div", v, 32'h0000_FFFF);
      bus_rd(REG_ERR, v);     chk("reset_err", v, 32'h0);
      bus_rd(REG_DATA, v);    chk("empty_data_read", v, 32'hFFFF_FFFF);
      @(negedge clk);
      address_in = {28'h0, REG_STATUS, 2'b00}; sel_in = 1'b0; read_in = 1'b1;
      #1 chk("unselected_read", read_value_out, 32'h0);
      read_in = 1'b0;

      bus_wr(REG_CLK_DIV, 32'hABCD_1203, 4'h1);
      bus_rd(REG_CLK_DIV, v); chk("clk_div_lane0", v, 32'h0000_FF03);
      bus_wr(REG_CLK_DIV, 32'h0000_0000, 4'h2);
      bus_rd(REG_CLK_DIV, v); chk("clk_div_lane1", v, 32'h0000_0003);
      p_cyc = 4;

      // 0x55 at 4 clk per bit, checked near the start and the end of each bit.
      pat = 10'b1010101010;
      bus_wr(REG_DATA, 32'h0000_0055, 4'h1);
      tx_exp_q.push_back(8'h55);
      k = 0;
      while (tx_out !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("tx55_start_seen", {31'h0, (k < 200)}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         chk("tx55_bit_early", {31'h0, tx_out}, {31'h0, pat[i]});
         repeat (3) @(negedge clk);
         chk("tx55_bit_late", {31'h0, tx_out}, {31'h0, pat[i]});
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      bus_rd(REG_STATUS, v); chk("tx55_idle_status", v, 32'h0000_0009);

      // Keep TX busy, then overfill the FIFO by one.
      bus_wr(REG_DATA, 32'h0000_0011, 4'h1);
      tx_exp_q.push_back(8'h11);
      repeat (3) @(negedge clk);
      b2b = 0;
      for (int i = 0; i < 17; i++) begin
         bus_wr(REG_DATA, 32'(8'h20 + i), 4'h1);
         if (i < 16) tx_exp_q.push_back(8'(8'h20 + i));
      end
      bus_rd(REG_STATUS, v); chk("tx_full_status", v, 32'h0000_1004);
      k = 0;
      while (tx_exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("tx_drain", 32'(tx_exp_q.size()), 32'h0);
      repeat (6) @(negedge clk);
      chk("tx_back_to_back", 32'(b2b), 32'd16);
      bus_rd(REG_STATUS, v); chk("tx_drained_status", v, 32'h0000_0009);
      bus_rd(REG_ERR, v);    chk("tx_overflow_err", v, 32'h0000_0004);
      bus_wr(REG_ERR, 32'h0000_0004, 4'h1);
      bus_rd(REG_ERR, v);    chk("tx_overflow_clr", v, 32'h0);

      // Receive 0xA3 at CLK_DIV=7.
      set_div(7);
      rx_exp_q.push_back(32'h0000_00A3);
      send_rx(8'hA3, 1'b1, 1'b0, 1'b0);
      bus_rd(REG_STATUS, v); chk("rx_a3_status", v, 32'h0001_000B);
      bus_rd(REG_DATA, v);   chk("rx_a3_data", v, rx_exp_q.pop_front());
      bus_rd(REG_DATA, v);   chk("rx_a3_empty", v, 32'hFFFF_FFFF);

      // Two-cycle glitch must be rejected at mid-start.
      @(negedge clk) rx_in = 1'b0;
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
      repeat (30) @(negedge clk);
      bus_rd(REG_STATUS, v); chk("glitch_status", v, 32'h0000_0009);
      bus_rd(REG_ERR, v);    chk("glitch_err", v, 32'h0);

      // Stop bit low: framing error, no push, then clear.
      send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
      bus_rd(REG_ERR, v);    chk("framing_err", v, 32'h0000_0001);
      bus_rd(REG_STATUS, v); chk("framing_status", v, 32'h0000_0009);
      bus_wr(REG_ERR, 32'h0000_0001, 4'h1);
      bus_rd(REG_ERR, v);    chk("framing_clr", v, 32'h0);

`ifdef BUFFERED_UART_PARITY_EN
      bus_wr(REG_ERR, 32'h0000_0100, 4'h2);
      bus_rd(REG_ERR, v);    chk("parity_cfg", v, 32'h0000_0100);
      send_rx(8'h07, 1'b1, 1'b1, 1'b0);
      bus_rd(REG_ERR, v);    chk("parity_err", v, 32'h0000_0108);
      bus_rd(REG_STATUS, v); chk("parity_drop_status", v, 32'h0000_0009);
      bus_wr(REG_ERR, 32'h0000_0008, 4'h1);
      bus_rd(REG_ERR, v);    chk("parity_clr", v, 32'h0000_0100);
      rx_exp_q.push_back(32'h0000_0007);
      send_rx(8'h07, 1'b1, 1'b1, 1'b1);
      bus_rd(REG_DATA, v);   chk("parity_good_data", v, rx_exp_q.pop_front());
      bus_wr(REG_ERR, 32'h0000_0000, 4'h2);
`else
      bus_wr(REG_ERR, 32'h0000_030F, 4'h3);
      bus_rd(REG_ERR, v);    chk("no_parity_err_bits", v, 32'h0);
`endif

      // Seventeen frames into a 16-deep RX FIFO: last one is an overrun.
      set_div(3);
      for (int i = 0; i < 17; i++) begin
         send_rx(8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
         if (i < 16) rx_exp_q.push_back(32'(8'h40 + i));
      end
      bus_rd(REG_STATUS, v); chk("rx_full_status", v, 32'h0010_000B);
      bus_rd(REG_ERR, v);    chk("rx_overrun_err", v, 32'h0000_0002);
      for (int i = 0; i < 16; i++) begin
         bus_rd(REG_DATA, v); chk("rx_fifo_data", v, rx_exp_q.pop_front());
      end
      bus_rd(REG_DATA, v);   chk("rx_fifo_drained", v, 32'hFFFF_FFFF);

      repeat (10) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/buffered_uart.md
BUFFERED_UART -- requirements
Module: buffered_uart

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, entries per RX and TX FIFO (power of two, 2..256).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the clock-divider register (8..24).
REQ-003 SHALL have port clk  input  1  clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_in  input  1  serial receive line, idle high, already synchronised to clk.
REQ-006 SHALL have port tx_out  output  1  serial transmit line, idle high.
REQ-007 SHALL have port address_in  input  32  byte address; only bits [3:2] are decoded.
REQ-008 SHALL have port sel_in  input  1  bus select.
REQ-009 SHALL have port read_in  input  1  read strobe, qualified by sel_in.
REQ-010 SHALL have port read_value_out  output  32  combinational read data; 0 when sel_in=0.
REQ-011 SHALL have port write_mask_in  input  4  byte write enables, qualified by sel_in.
REQ-012 SHALL have port write_value_in  input  32  write data.

Function
REQ-013 SHALL decode 0x0 CLK_DIV (RW [DIV_WIDTH-1:0]), 0x4 STATUS (RO), 0x8 DATA (RW), 0xC ERR (read; write-1-to-clear); byte lanes are honoured per write_mask_in.
REQ-014 SHALL define the bit period as CLK_DIV+1 clk cycles and use the CLK_DIV value in effect at each bit boundary.
REQ-015 SHALL report STATUS = {tx_level[15:8], rx_level[23:16], bit3 tx_idle, bit2 tx_full, bit1 rx_nonempty, bit0 tx_not_full}; levels are zero-extended 9-bit counts.
REQ-016 SHALL push write_value_in[7:0] into the TX FIFO on a DATA write with mask[0]=1; a write while the FIFO is full is dropped and sets ERR bit2 (tx_overflow).
REQ-017 SHALL return {24'b0, head} on a DATA read when the RX FIFO is non-empty and pop it on that cycle; when empty, SHALL return 0xFFFFFFFF with no pop.
REQ-018 SHALL run a TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE, each state lasting one bit period; it pops the FIFO on entering START; STOP is followed directly by START when the FIFO is non-empty (no idle gap).
REQ-019 SHALL run an RX FSM IDLE -> START -> DATA -> [PARITY] -> STOP; a falling edge in IDLE loads a half-bit count (CLK_DIV>>1); START is aborted back to IDLE if rx_in=1 at mid-bit.
REQ-020 SHALL push the received byte into the RX FIFO at mid-STOP when rx_in=1; when rx_in=0 at mid-STOP, SHALL discard the byte, set ERR bit0 (framing), and return to IDLE only after rx_in is seen high.
REQ-021 SHALL discard a completed byte when the RX FIFO is full and set ERR bit1 (rx_overrun); FIFO contents are unchanged.
REQ-022 SHALL make a simultaneous RX push and bus pop on the same cycle both succeed, including when full.
REQ-023 SHALL keep tx_out=1 in IDLE and STOP; tx_idle=1 only when the TX FSM is IDLE and the TX FIFO is empty.

Reset
REQ-024 SHALL on reset set both FSMs to IDLE, empty both FIFOs, clear ERR, set tx_out=1, and set CLK_DIV to all ones; a reset mid-frame truncates the frame immediately.
REQ-025 SHALL leave FIFO storage RAM uninitialised; only pointers and counts are reset.

Configuration
REQ-026 SHALL compile parity logic only when macro BUFFERED_UART_PARITY_EN is defined: ERR write-data bit8 (sticky config bit parity_on, reset 0) and bit9 (parity_odd) enable a parity bit after the data bits, an RX parity mismatch drops the byte and sets ERR bit3.
REQ-027 SHALL, without BUFFERED_UART_PARITY_EN, always use 10-bit frames; ERR bits 3, 8 and 9 read 0 and ignore writes.

Structure
REQ-028 SHALL place register offsets, STATUS/ERR bit positions and the TX/RX FSM state enums in package buffered_uart_pkg.
REQ-029 SHALL instantiate sub-module sync_fifo (parameters WIDTH=8, DEPTH) twice, exposing push, pop, full, empty and level.

Verification
REQ-030 SHALL cover: CLK_DIV=3, write 0x55 -> tx_out shows 0,1,0,1,0,1,0,1,0,1 at 4 clk per bit, then tx_idle=1.
REQ-031 SHALL cover: 17 DATA writes with FIFO_DEPTH=16 while TX is busy -> 16 bytes transmitted back-to-back, ERR bit2=1.
REQ-032 SHALL cover: drive 0xA3 on rx_in at CLK_DIV=7 -> STATUS bit1=1, DATA read returns 0x000000A3, next read returns 0xFFFFFFFF.
REQ-033 SHALL cover: a 2-clk low glitch on rx_in at CLK_DIV=7 -> no push, ERR=0.
REQ-034 SHALL cover: frame with stop bit 0 -> ERR bit0=1, no push; write 0x1 to ERR -> bit0 cleared.
REQ-035 SHALL cover: with BUFFERED_UART_PARITY_EN, parity_on=1 and even parity, receive 0x07 with parity bit 0 -> byte dropped, ERR bit3=1.
